mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch and
// data requesters. Data has fixed priority. A starvation counter forces a fetch grant
// after STARVE_MAX consecutive fetch losses. One transaction is outstanding at a time,
// and the memory read latency is fixed at LAT cycles.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch grant, response pulse, response data
//   d_req/d_we/d_addr/d_wdata   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata      data grant, read-data/write-ack pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port
//   busy                        a transaction is outstanding
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;

  localparam logic [1:0] LAT_INIT   = 2'(LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state_q, state_d;
  logic [1:0] lat_q, lat_d;
  logic       owner_q, owner_d;  // 0 = fetch, 1 = data
  logic       we_q, we_d;
  logic [3:0] starve_q, starve_d;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    we_d      = we_q;
    starve_d  = starve_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    busy      = 1'b0;

    // Outputs are held at zero while reset is asserted, so no grant can leak out
    // of a cycle whose state update is about to be discarded.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (if_req && (!d_req || starve_q == STARVE_LIM)) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
            owner_d  = 1'b0;
            we_d     = 1'b0;
            lat_d    = LAT_INIT;
            starve_d = 4'd0;
            state_d  = WAIT;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner_d   = 1'b1;
            we_d      = d_we;
            lat_d     = LAT_INIT;
            state_d   = WAIT;
            // Only count a loss when fetch was actually waiting; saturate at the limit.
            if (if_req && starve_q < STARVE_LIM) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
        WAIT: begin
          busy = 1'b1;
          if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
          end else begin
            state_d = IDLE;
            if (owner_q) begin
              d_rvalid = 1'b1;
              d_rdata  = we_q ? 32'd0 : mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_q    <= 2'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances (LAT = 1, 2, 4) share one
// stimulus; each scenario checks the instance whose latency it targets.
module tb_mem_port_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [31:0]   d_wdata, mem_rdata;

  logic          o1_if_gnt, o1_if_rvalid, o1_d_gnt, o1_d_rvalid, o1_mem_en, o1_mem_we, o1_busy;
  logic [31:0]   o1_if_rdata, o1_d_rdata, o1_mem_wdata;
  logic [AW-1:0] o1_mem_addr;
  logic          o2_if_gnt, o2_if_rvalid, o2_d_gnt, o2_d_rvalid, o2_mem_en, o2_mem_we, o2_busy;
  logic [31:0]   o2_if_rdata, o2_d_rdata, o2_mem_wdata;
  logic [AW-1:0] o2_mem_addr;
  logic          o4_if_gnt, o4_if_rvalid, o4_d_gnt, o4_d_rvalid, o4_mem_en, o4_mem_we, o4_busy;
  logic [31:0]   o4_if_rdata, o4_d_rdata, o4_mem_wdata;
  logic [AW-1:0] o4_mem_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .LAT(1), .STARVE_MAX(3)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o1_if_gnt), .if_rvalid(o1_if_rvalid),
    .if_rdata(o1_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o1_d_gnt),
    .d_rvalid(o1_d_rvalid), .d_rdata(o1_d_rdata),
    .mem_en(o1_mem_en), .mem_we(o1_mem_we), .mem_addr(o1_mem_addr), .mem_wdata(o1_mem_wdata),
    .mem_rdata(mem_rdata), .busy(o1_busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .LAT(2), .STARVE_MAX(3)) u2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o2_if_gnt), .if_rvalid(o2_if_rvalid),
    .if_rdata(o2_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o2_d_gnt),
    .d_rvalid(o2_d_rvalid), .d_rdata(o2_d_rdata),
    .mem_en(o2_mem_en), .mem_we(o2_mem_we), .mem_addr(o2_mem_addr), .mem_wdata(o2_mem_wdata),
    .mem_rdata(mem_rdata), .busy(o2_busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .LAT(4), .STARVE_MAX(3)) u4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o4_if_gnt), .if_rvalid(o4_if_rvalid),
    .if_rdata(o4_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o4_d_gnt),
    .d_rvalid(o4_d_rvalid), .d_rdata(o4_d_rdata),
    .mem_en(o4_mem_en), .mem_we(o4_mem_we), .mem_addr(o4_mem_addr), .mem_wdata(o4_mem_wdata),
    .mem_rdata(mem_rdata), .busy(o4_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = 32'd0;
    mem_rdata = 32'd0;
  endtask

  // Returns at a falling edge with reset just released and all instances in IDLE.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic exp_fetch;
    rst = 1'b1;
    clear_inputs();
    if_req  = 1'b1;
    if_addr = 11'h010;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_wdata = 32'hFFFF_FFFF;

    // Reset: every output zero even with both requests present.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs",
        32'({o1_if_gnt, o1_if_rvalid, o1_d_gnt, o1_d_rvalid, o1_mem_en, o1_mem_we, o1_busy}),
        32'd0);
    chk("reset_buses", o1_mem_wdata | o1_if_rdata | o1_d_rdata | 32'(o1_mem_addr), 32'd0);
    chk("reset_starve", 32'(u1.starve_q), 32'd0);

    // Single fetch, LAT=1.
    do_reset();
    if_req    = 1'b1;
    if_addr   = 11'h010;
    mem_rdata = 32'h2402_000A;
    #1;
    chk1("f1_if_gnt", o1_if_gnt, 1'b1);
    chk1("f1_d_gnt", o1_d_gnt, 1'b0);
    chk1("f1_mem_en", o1_mem_en, 1'b1);
    chk1("f1_mem_we", o1_mem_we, 1'b0);
    chk("f1_mem_addr", 32'(o1_mem_addr), 32'h010);
    chk1("f1_busy_t", o1_busy, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk1("f1_if_rvalid", o1_if_rvalid, 1'b1);
    chk("f1_if_rdata", o1_if_rdata, 32'h2402_000A);
    chk1("f1_busy_t1", o1_busy, 1'b1);
    chk1("f1_mem_en_wait", o1_mem_en, 1'b0);
    @(negedge clk);
    #1;
    chk1("f1_busy_t2", o1_busy, 1'b0);
    chk1("f1_rvalid_t2", o1_if_rvalid, 1'b0);
    chk("f1_rdata_t2", o1_if_rdata, 32'd0);

    // Data write then read, LAT=2.
    do_reset();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 11'h005;
    d_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("wr_d_gnt", o2_d_gnt, 1'b1);
    chk1("wr_mem_we", o2_mem_we, 1'b1);
    chk("wr_mem_addr", 32'(o2_mem_addr), 32'h005);
    chk("wr_mem_wdata", o2_mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk1("wr_rvalid_t1", o2_d_rvalid, 1'b0);
    @(negedge clk);
    mem_rdata = 32'h1234_5678;
    #1;
    chk1("wr_ack", o2_d_rvalid, 1'b1);
    chk("wr_ack_rdata", o2_d_rdata, 32'd0);
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_wdata = 32'd0;
    #1;
    chk1("rd_d_gnt", o2_d_gnt, 1'b1);
    chk1("rd_mem_we", o2_mem_we, 1'b0);
    chk("rd_mem_addr", 32'(o2_mem_addr), 32'h005);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk1("rd_rvalid_t4", o2_d_rvalid, 1'b0);
    @(negedge clk);
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("rd_rvalid", o2_d_rvalid, 1'b1);
    chk("rd_rdata", o2_d_rdata, 32'hDEAD_BEEF);
    chk1("rd_no_if_rvalid", o2_if_rvalid, 1'b0);
    chk("rd_starve_hold", 32'(u2.starve_q), 32'd0);

    // Contention, LAT=1, STARVE_MAX=3: grants D,D,D,I repeating every 2 cycles.
    do_reset();
    if_req    = 1'b1;
    if_addr   = 11'h020;
    d_req     = 1'b1;
    d_addr    = 11'h030;
    exp_fetch = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      if (s % 2 == 0) begin
        exp_fetch = ((s / 2) % 4 == 3);
        chk1($sformatf("ct_if_gnt_%0d", s / 2), o1_if_gnt, exp_fetch);
        chk1($sformatf("ct_d_gnt_%0d", s / 2), o1_d_gnt, !exp_fetch);
        chk($sformatf("ct_addr_%0d", s / 2), 32'(o1_mem_addr), exp_fetch ? 32'h020 : 32'h030);
      end else begin
        chk1($sformatf("ct_if_rv_%0d", s / 2), o1_if_rvalid, exp_fetch);
        chk1($sformatf("ct_d_rv_%0d", s / 2), o1_d_rvalid, !exp_fetch);
        chk($sformatf("ct_starve_%0d", s / 2), 32'(u1.starve_q),
            ((s / 2) % 4 == 3) ? 32'd0 : 32'((s / 2) % 4 + 1));
      end
    end

    // No requests for 10 cycles.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("idle_%0d", c),
          32'({o1_mem_en, o1_mem_we, o1_if_gnt, o1_d_gnt, o1_if_rvalid, o1_d_rvalid, o1_busy}),
          32'd0);
    end

    // Reset mid-WAIT, LAT=4: the data read never completes; a fetch follows.
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 11'h040;
    mem_rdata = 32'hCAFE_0001;
    #1;
    chk1("rm_d_gnt", o4_d_gnt, 1'b1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk1("rm_busy_t1", o4_busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rm_rvalid_t2", o4_d_rvalid, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 11'h011;
    #1;
    chk1("rm_busy_t3", o4_busy, 1'b0);
    chk1("rm_d_rvalid_t3", o4_d_rvalid, 1'b0);
    chk1("rm_if_gnt_t3", o4_if_gnt, 1'b1);
    chk("rm_addr_t3", 32'(o4_mem_addr), 32'h011);
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk1($sformatf("rm_d_rvalid_t%0d", k), o4_d_rvalid, 1'b0);
      chk1($sformatf("rm_if_rvalid_t%0d", k), o4_if_rvalid, k == 7);
    end

    // Data request raised during WAIT and dropped before IDLE: never granted.
    do_reset();
    if_req  = 1'b1;
    if_addr = 11'h003;
    #1;
    chk1("dr_if_gnt", o2_if_gnt, 1'b1);
    @(negedge clk);
    if_req  = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 11'h007;
    d_wdata = 32'h0BAD_F00D;
    #1;
    chk("dr_t1", 32'({o2_d_gnt, o2_mem_we}), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk($sformatf("dr_t%0d", k), 32'({o2_d_gnt, o2_mem_we, o2_d_rvalid}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
